sms_clk_reset_seq: RTL and testbench

//  Sits directly downstream of the SMS system PLL. Runs on its 53.693175 MHz output clock.

---
 rtl/sms_clk_pkg.sv | 26 ++
 rtl/sms_clk_reset_seq_if.sv | 36 +++
 rtl/sms_ce_div.sv | 24 ++
 rtl/sms_clk_reset_seq.sv | 147 ++++++++++++++
 tb/tb_sms_clk_reset_seq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sms_clk_pkg.sv
// sms_clk_pkg: shared state type, default divisors and width helpers for the SMS clock/reset sequencer
package sms_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        RUN,
        HOLD
    } state_t;

    localparam int CPU_DIV_DEF = 15;
    localparam int VDP_DIV_DEF = 10;
    localparam int PSG_DIV_DEF = 16;
    localparam int TURBO_DIV   = 7;

    // Width of a counter that walks 0..n-1 (never narrower than one bit)
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a field that must hold the value n itself
    function automatic int val_w(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sms_clk_reset_seq_if.sv
// sms_clk_reset_seq_if: lock/reset-request inputs and core reset/clock-enable outputs of the sequencer.
// With SMS_CE_TURBO_EN defined the bundle also carries the synchronous turbo select.
interface sms_clk_reset_seq_if;

    logic pll_locked;
    logic reset_req;
    logic core_reset;
    logic ready;
    logic ce_cpu;
    logic ce_vdp;
    logic ce_psg;
`ifdef SMS_CE_TURBO_EN
    logic turbo;

    modport master (
        output pll_locked, reset_req, turbo,
        input  core_reset, ready, ce_cpu, ce_vdp, ce_psg
    );

    modport slave (
        input  pll_locked, reset_req, turbo,
        output core_reset, ready, ce_cpu, ce_vdp, ce_psg
    );
`else
    modport master (
        output pll_locked, reset_req,
        input  core_reset, ready, ce_cpu, ce_vdp, ce_psg
    );

    modport slave (
        input  pll_locked, reset_req,
        output core_reset, ready, ce_cpu, ce_vdp, ce_psg
    );
`endif

endinterface

// File: rtl/sms_ce_div.sv
// sms_ce_div: modulo-N counter with enable, synchronous clear and runtime divisor; ce marks the wrap cycle
module sms_ce_div #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_n,
    output logic         o_ce
);

    logic [W-1:0] r_cnt;

    assign o_ce = i_en && (r_cnt == i_n - 1'b1);

    // Count enabled cycles, wrapping to zero on the ce cycle; clear overrides counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= o_ce ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/sms_clk_reset_seq.sv
// sms_clk_reset_seq: qualifies PLL lock, sequences the SMS core reset and generates CPU/VDP/PSG clock enables.
// Optional feature macro: SMS_CE_TURBO_EN (adds turbo select, CPU divide 7 while set).
module sms_clk_reset_seq
    import sms_clk_pkg::*;
#(
    parameter int CPU_DIV       = CPU_DIV_DEF,
    parameter int VDP_DIV       = VDP_DIV_DEF,
    parameter int PSG_DIV       = PSG_DIV_DEF,
    parameter int STABLE_CYCLES = 65536,
    parameter int HOLD_CYCLES   = 1024
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    sms_clk_reset_seq_if.slave    bus
);

    localparam int SW = cnt_w(STABLE_CYCLES);
    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int CW = val_w(CPU_DIV > TURBO_DIV ? CPU_DIV : TURBO_DIV);
    localparam int VW = val_w(VDP_DIV);
    localparam int PW = val_w(PSG_DIV);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);

    logic [1:0]    r_sync;
    state_t        r_state;
    state_t        w_next_state;
    logic [SW-1:0] r_stable_cnt;
    logic [SW-1:0] w_stable_next;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_next;
    logic          r_core_reset;
    logic          r_ready;
    logic [CW-1:0] r_cpu_n;
    logic [CW-1:0] w_cpu_sel;
    logic          w_lk;
    logic          w_run;
    logic          w_ce_cpu;
    logic          w_ce_vdp;
    logic          w_ce_psg;

    assign w_lk  = r_sync[1];
    assign w_run = (r_state == RUN);

    // Two-flop synchroniser: the only path from the asynchronous PLL lock into this domain
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b00;
        else r_sync <= {r_sync[0], bus.pll_locked};
    end

    // Next-state and counter decisions; lock loss always takes priority over a reset request
    always_comb begin
        w_next_state  = r_state;
        w_stable_next = r_stable_cnt;
        w_hold_next   = r_hold_cnt;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lk) begin
                    w_next_state  = STABLE;
                    w_stable_next = '0;
                end
            end
            STABLE: begin
                if (!w_lk) w_next_state = WAIT_LOCK;
                else if (r_stable_cnt == STABLE_LAST) w_next_state = RUN;
                else w_stable_next = r_stable_cnt + 1'b1;
            end
            RUN: begin
                if (!w_lk) w_next_state = WAIT_LOCK;
                else if (bus.reset_req) begin
                    w_next_state = HOLD;
                    w_hold_next  = '0;
                end
            end
            HOLD: begin
                if (!w_lk) w_next_state = WAIT_LOCK;
                else if (bus.reset_req) w_hold_next = '0;
                else if (r_hold_cnt == HOLD_LAST) w_next_state = RUN;
                else w_hold_next = r_hold_cnt + 1'b1;
            end
            default: w_next_state = WAIT_LOCK;
        endcase
    end

    // State, counters and the registered core_reset/ready decoded from the next state
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_LOCK;
            r_stable_cnt <= '0;
            r_hold_cnt   <= '0;
            r_core_reset <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_stable_cnt <= w_stable_next;
            r_hold_cnt   <= w_hold_next;
            r_core_reset <= (w_next_state != RUN);
            r_ready      <= (w_next_state == RUN);
        end
    end

`ifdef SMS_CE_TURBO_EN
    assign w_cpu_sel = bus.turbo ? CW'(TURBO_DIV) : CW'(CPU_DIV);
`else
    assign w_cpu_sel = CW'(CPU_DIV);
`endif

    // CPU divisor only changes at a counter wrap (or while idle) so every ce_cpu period is whole
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) r_cpu_n <= CW'(CPU_DIV);
        else if (!w_run || w_ce_cpu) r_cpu_n <= w_cpu_sel;
    end

    sms_ce_div #(.W(CW)) u_cpu_div (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .i_en  (w_run),
        .i_clr (!w_run),
        .i_n   (r_cpu_n),
        .o_ce  (w_ce_cpu)
    );

    sms_ce_div #(.W(VW)) u_vdp_div (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .i_en  (w_run),
        .i_clr (!w_run),
        .i_n   (VW'(VDP_DIV)),
        .o_ce  (w_ce_vdp)
    );

    sms_ce_div #(.W(PW)) u_psg_div (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .i_en  (w_ce_cpu),
        .i_clr (!w_run),
        .i_n   (PW'(PSG_DIV)),
        .o_ce  (w_ce_psg)
    );

    assign bus.core_reset = r_core_reset;
    assign bus.ready      = r_ready;
    assign bus.ce_cpu     = w_ce_cpu;
    assign bus.ce_vdp     = w_ce_vdp;
    assign bus.ce_psg     = w_ce_psg;

endmodule

// File: tb/tb_sms_clk_reset_seq.sv
// tb_sms_clk_reset_seq: self-checking bench with an event-time reference model of the sequencer
module tb_sms_clk_reset_seq;

    localparam int STABLE = 16;
    localparam int HOLD   = 8;
    localparam int CPU    = 15;
    localparam int VDP    = 10;
    localparam int PSG    = 16;
    localparam int TURBO  = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sms_clk_reset_seq_if bus();

    sms_clk_reset_seq #(
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD)
    ) dut (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: lock seen two edges after sampling, release by elapsed edge counts,
    // clock enables from the time elapsed since RUN entry.
    logic hist[$];
    bit   m_run = 0;
    bit   m_hold = 0;
    int   lock_since = -1;
    int   last_req = 0;
    int   edge_n = 0;
    int   t = 0;
    int   cpu_next = 0;
    int   cpu_cnt = 0;

    function automatic bit cur_turbo();
`ifdef SMS_CE_TURBO_EN
        return bus.turbo;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int period(input bit tb);
        return tb ? TURBO : CPU;
    endfunction

    task automatic start_run(input bit tb);
        m_run = 1;
        m_hold = 0;
        t = 0;
        cpu_next = period(tb) - 1;
        cpu_cnt = 0;
    endtask

    task automatic model_step();
        logic lk;
        bit   req;
        bit   tb;
        if (!rst_n) begin
            hist.delete();
            m_run = 0;
            m_hold = 0;
            lock_since = -1;
            edge_n = 0;
        end else begin
            lk = (hist.size() == 2) ? hist[0] : 1'b0;
            hist.push_back(bus.pll_locked);
            if (hist.size() > 2) void'(hist.pop_front());
            edge_n++;
            req = bus.reset_req;
            tb = cur_turbo();
            if (lk !== 1'b1) begin
                m_run = 0;
                m_hold = 0;
                lock_since = -1;
            end else if (m_run) begin
                if (req) begin
                    m_run = 0;
                    m_hold = 1;
                    last_req = edge_n;
                end else begin
                    if (t == cpu_next) begin
                        cpu_cnt++;
                        cpu_next = t + period(tb);
                    end
                    t++;
                end
            end else if (m_hold) begin
                if (req) last_req = edge_n;
                else if (edge_n - last_req == HOLD) start_run(tb);
            end else begin
                if (lock_since < 0) lock_since = edge_n;
                else if (edge_n - lock_since == STABLE) start_run(tb);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        bit e_cpu;
        @(negedge clk);
        e_cpu = m_run && (t == cpu_next);
        check("core_reset", bus.core_reset, !m_run);
        check("ready", bus.ready, m_run);
        check("ce_vdp", bus.ce_vdp, m_run && (t % VDP == VDP - 1));
        check("ce_cpu", bus.ce_cpu, e_cpu);
        check("ce_psg", bus.ce_psg, e_cpu && (cpu_cnt % PSG == PSG - 1));
    end

    task automatic wait_release(output int k);
        for (k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (!bus.core_reset) break;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.reset_req = $urandom_range(0, 1) == 0 && !bus.ready;
        end
        bus.reset_req = 1'b0;
    endtask

    initial begin
        int k;
        int n_vdp;
        int n_cpu;
        int n_co;
        int first_psg;
        bus.pll_locked = 1'b0;
        bus.reset_req = 1'b0;
`ifdef SMS_CE_TURBO_EN
        bus.turbo = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_core_reset", bus.core_reset, 1);
        check("reset_ready", bus.ready, 0);
        rst_n = 1'b1;
        idle(4);
        // Lock assert: reset_req toggling before lock is ignored
        bus.pll_locked = 1'b1;
        for (k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (!bus.core_reset) break;
            bus.reset_req = k > 5 && k < 15 && ($urandom_range(0, 1) == 1);
        end
        bus.reset_req = 1'b0;
        check("lock_release_cycle", k, 19);
        check("ready_at_release", bus.ready, 1);
        idle($urandom_range(3, 20));
        // Lock glitch during STABLE restarts the full count
        bus.pll_locked = 1'b0;
        idle(5);
        bus.pll_locked = 1'b1;
        repeat (12) @(negedge clk);
        bus.pll_locked = 1'b0;
        @(negedge clk);
        bus.pll_locked = 1'b1;
        wait_release(k);
        check("glitch_release_cycle", k, 19);
        // Divider cadence over 300 RUN cycles
        n_vdp = 0; n_cpu = 0; n_co = 0; first_psg = 0;
        for (int i = 1; i <= 300; i++) begin
            if (i > 1) @(negedge clk);
            n_vdp += int'(bus.ce_vdp);
            n_cpu += int'(bus.ce_cpu);
            n_co += int'(bus.ce_vdp && bus.ce_cpu);
            if (bus.ce_psg && first_psg == 0) first_psg = i;
        end
        check("vdp_pulses_300", n_vdp, 30);
        check("cpu_pulses_300", n_cpu, 20);
        check("coincident_300", n_co, 10);
        check("first_psg_cycle", first_psg, 240);
        idle($urandom_range(1, 17));
        // Single reset_req pulse stretches to exactly HOLD cycles
        bus.reset_req = 1'b1;
        @(negedge clk);
        bus.reset_req = 1'b0;
        k = 0;
        while (bus.core_reset && k < 60) begin
            k++;
            @(negedge clk);
        end
        check("hold_len", k, 8);
        for (k = 1; k <= 40; k++) begin
            if (bus.ce_vdp) break;
            @(negedge clk);
        end
        check("first_vdp_after_hold", k, 10);
        idle($urandom_range(1, 23));
        // Second pulse at hold count 5 restarts the stretch
        bus.reset_req = 1'b1;
        @(negedge clk);
        bus.reset_req = 1'b0;
        k = 0;
        while (bus.core_reset && k < 60) begin
            k++;
            bus.reset_req = (k == 6);
            @(negedge clk);
        end
        bus.reset_req = 1'b0;
        check("hold_restart_len", k, 14);
        idle($urandom_range(5, 40));
        // Lock loss and reset_req reach the FSM on the same edge
        bus.pll_locked = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.reset_req = 1'b1;
        @(negedge clk);
        bus.reset_req = 1'b0;
        check("simul_core_reset", bus.core_reset, 1);
        check("simul_ready", bus.ready, 0);
        bus.pll_locked = 1'b1;
        wait_release(k);
        check("simul_release_cycle", k, 19);
        idle($urandom_range(20, 60));
        // Asynchronous reset mid-RUN
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_core_reset", bus.core_reset, 1);
        check("async_ready", bus.ready, 0);
        check("async_ce", {bus.ce_cpu, bus.ce_vdp, bus.ce_psg}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_release(k);
        check("post_rst_release_cycle", k, 19);
`ifdef SMS_CE_TURBO_EN
        // Turbo toggled mid-period: current period completes, then 7-cycle periods
        for (k = 0; k < 40 && !bus.ce_cpu; k++) @(negedge clk);
        begin
            int last;
            int nth;
            last = 0;
            nth = 0;
            for (int i = 0; i <= 90; i++) begin
                if (i > 0) @(negedge clk);
                if (i == 5) bus.turbo = 1'b1;
                if (bus.ce_cpu && i > 0) begin
                    nth++;
                    check("turbo_interval_legal", (i - last == 7 || i - last == 15), 1);
                    if (nth == 1) check("turbo_first_interval", i - last, 15);
                    if (nth == 2) check("turbo_second_interval", i - last, 7);
                    last = i;
                end
            end
        end
        bus.turbo = 1'b0;
        idle(60);
`endif
        idle(20);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
